// File: rtl/ip_pkg.sv
// ip_pkg: shared constants for the inner-product accumulator block.
//   - Data widths (DW, FRAC, PW, AW) and counter widths
//   - FSM state encoding
//   - Saturation limits and sign-extension helpers
package ip_pkg;

  localparam int DW    = 16;  // output neuron / bias width (signed fixed point)
  localparam int FRAC  = 8;   // fractional bits of DW data
  localparam int PW    = 32;  // partial-product width (signed, 2*FRAC frac bits)
  localparam int AW    = 48;  // accumulator width (signed)
  localparam int INN_W = 15;  // input-neuron count width
  localparam int ONN_W = 13;  // output-neuron count / index width

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACC   = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_WRITE = 2'd3;

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Sign-extend a MAC partial product to accumulator width.
  function automatic logic [AW-1:0] sext_psum(input logic [PW-1:0] p);
    return {{(AW-PW){p[PW-1]}}, p};
  endfunction

  // Bias has FRAC fractional bits; psums carry 2*FRAC, so align by FRAC.
  function automatic logic [AW-1:0] bias_to_acc(input logic [DW-1:0] b);
    return {{(AW-DW-FRAC){b[DW-1]}}, b, {FRAC{1'b0}}};
  endfunction

endpackage

// File: rtl/ip_round_sat.sv
// ip_round_sat: combinational result stage for one output neuron.
//   Rounds the 2*FRAC-fraction accumulator to FRAC fraction bits
//   (round-half-up toward +inf), optionally clamps negatives to zero,
//   then saturates to the signed DW range.
// Ports:
//   acc     in  AW  signed accumulator value
//   relu_en in  1   clamp negative results to zero
//   result  out DW  rounded, ReLU'd, saturated result
module ip_round_sat
  import ip_pkg::*;
(
  input  logic [AW-1:0] acc,
  input  logic          relu_en,
  output logic [DW-1:0] result
);

  localparam logic signed [AW-1:0] HALF_C   = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] MAX_AW_C = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_AW_C = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] rnd_s;
  logic signed [AW-1:0] shr_s;
  logic        [DW-1:0] result_s;

  // Round, ReLU, then saturate.
  always_comb begin
    rnd_s    = $signed(acc) + HALF_C;
    shr_s    = rnd_s >>> FRAC;
    result_s = {DW{1'b0}};
    if (relu_en && shr_s[AW-1]) begin
      result_s = {DW{1'b0}};
    end else if (shr_s > MAX_AW_C) begin
      result_s = SAT_MAX;
    end else if (shr_s < MIN_AW_C) begin
      result_s = SAT_MIN;
    end else begin
      result_s = shr_s[DW-1:0];
    end
  end

  assign result = result_s;

endmodule

// File: rtl/ip_accum.sv
// ip_accum: output-neuron accumulator downstream of the inner-product MAC.
//   Seeds the accumulator with the bias, sums inn_i partial products,
//   rounds / ReLUs / saturates, writes the result to the output buffer and
//   pulses output_en_o so the FC controller can start the next neuron.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   oneuron_start_i         start a new output neuron (IDLE only)
//   inn_i, onn_i            input neurons per output / output neurons in layer
//   relu_en_i, bias_i       per-neuron ReLU enable and bias
//   psum_valid_i, psum_i    partial product stream from the MAC
//   out_we_o, out_addr_o,
//   out_data_o              output buffer write port
//   output_en_o             one-cycle "neuron written" pulse
//   layer_done_o            one-cycle pulse on the last neuron of the layer
//   busy_o                  FSM not idle
//   err_o                   sticky protocol-error flag
module ip_accum
  import ip_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             oneuron_start_i,
  input  logic [INN_W-1:0] inn_i,
  input  logic [ONN_W-1:0] onn_i,
  input  logic             relu_en_i,
  input  logic [DW-1:0]    bias_i,
  input  logic             psum_valid_i,
  input  logic [PW-1:0]    psum_i,
  output logic             out_we_o,
  output logic [ONN_W-1:0] out_addr_o,
  output logic [DW-1:0]    out_data_o,
  output logic             output_en_o,
  output logic             layer_done_o,
  output logic             busy_o,
  output logic             err_o
);

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    acc_r;
  logic [INN_W-1:0] cnt_r, inn_r;
  logic [ONN_W-1:0] onn_r, idx_r;
  logic             relu_r;
  logic [DW-1:0]    round_res_s;

  logic             we_r, ld_r, busy_r, err_r;
  logic [ONN_W-1:0] addr_r;
  logic [DW-1:0]    data_r;

  logic             we_nxt_s, ld_nxt_s, busy_nxt_s, err_evt_s;
  logic             last_psum_s;

  ip_round_sat u_round_sat (
    .acc     (acc_r),
    .relu_en (relu_r),
    .result  (round_res_s)
  );

  assign last_psum_s = psum_valid_i && (cnt_r == (inn_r - 15'd1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (oneuron_start_i) begin
          state_nxt_s = (inn_i == 15'd0) ? ST_ROUND : ST_ACC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (last_psum_s) begin
          state_nxt_s = ST_ROUND;
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_ROUND: state_nxt_s = ST_WRITE;
      ST_WRITE: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered output strobes/flags.
  always_comb begin
    we_nxt_s   = (state_nxt_s == ST_WRITE);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    // idx is stable from ROUND into WRITE, so the layer-end compare is made here.
    ld_nxt_s   = (state_r == ST_ROUND) && (idx_r == (onn_r - 13'd1));
    err_evt_s  = (oneuron_start_i && (state_r != ST_IDLE)) ||
                 (psum_valid_i    && (state_r != ST_ACC));
  end

  // Accumulator datapath, per-neuron configuration and output index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_r  <= {AW{1'b0}};
      cnt_r  <= 15'd0;
      inn_r  <= 15'd0;
      onn_r  <= 13'd0;
      relu_r <= 1'b0;
      idx_r  <= 13'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (oneuron_start_i) begin
            acc_r  <= bias_to_acc(bias_i);
            cnt_r  <= 15'd0;
            inn_r  <= inn_i;
            relu_r <= relu_en_i;
            // Layer size is only taken at the first neuron of a layer.
            if (idx_r == 13'd0) begin
              onn_r <= onn_i;
            end else begin
              onn_r <= onn_r;
            end
          end else begin
            acc_r <= acc_r;
          end
        end
        ST_ACC: begin
          if (psum_valid_i) begin
            acc_r <= acc_r + sext_psum(psum_i);
            cnt_r <= cnt_r + 15'd1;
          end else begin
            acc_r <= acc_r;
          end
        end
        ST_WRITE: begin
          if (idx_r == (onn_r - 13'd1)) begin
            idx_r <= 13'd0;
          end else begin
            idx_r <= idx_r + 13'd1;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Registered outputs; data/addr captured in ROUND and held afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_r   <= 1'b0;
      ld_r   <= 1'b0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
      addr_r <= 13'd0;
      data_r <= {DW{1'b0}};
    end else begin
      we_r   <= we_nxt_s;
      ld_r   <= ld_nxt_s;
      busy_r <= busy_nxt_s;
      err_r  <= err_r | err_evt_s;
      if (state_r == ST_ROUND) begin
        addr_r <= idx_r;
        data_r <= round_res_s;
      end else begin
        addr_r <= addr_r;
        data_r <= data_r;
      end
    end
  end

  assign out_we_o     = we_r;
  assign output_en_o  = we_r;
  assign layer_done_o = ld_r;
  assign out_addr_o   = addr_r;
  assign out_data_o   = data_r;
  assign busy_o       = busy_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_ip_accum.sv
module tb_ip_accum;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        oneuron_start_i;
  logic [14:0] inn_i;
  logic [12:0] onn_i;
  logic        relu_en_i;
  logic [15:0] bias_i;
  logic        psum_valid_i;
  logic [31:0] psum_i;
  logic        out_we_o;
  logic [12:0] out_addr_o;
  logic [15:0] out_data_o;
  logic        output_en_o;
  logic        layer_done_o;
  logic        busy_o;
  logic        err_o;

  ip_accum dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .oneuron_start_i (oneuron_start_i),
    .inn_i           (inn_i),
    .onn_i           (onn_i),
    .relu_en_i       (relu_en_i),
    .bias_i          (bias_i),
    .psum_valid_i    (psum_valid_i),
    .psum_i          (psum_i),
    .out_we_o        (out_we_o),
    .out_addr_o      (out_addr_o),
    .out_data_o      (out_data_o),
    .output_en_o     (output_en_o),
    .layer_done_o    (layer_done_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [12:0] addr;
    logic [15:0] data;
    logic        ld;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Scoreboard: every write is popped and compared against the pushed expectation.
  always @(negedge clk_i) begin
    check_eq("en_eq_we", 32'(output_en_o), 32'(out_we_o));
    if (out_we_o) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 32'(out_we_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("addr", 32'(out_addr_o), 32'(mon_e.addr));
        check_eq("data", 32'(out_data_o), 32'(mon_e.data));
        check_eq("layer_done", 32'(layer_done_o), 32'(mon_e.ld));
        check_eq("latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      check_eq("ld_no_write", 32'(layer_done_o), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 64) begin
      tick();
      n++;
    end
    check_eq("drain", 32'(exp_q.size() == 0 && !busy_o), 32'd1);
  endtask

  // One neuron with inn identical psums, 'gap' idle cycles between psums.
  task automatic run_neuron(input logic [14:0] inn, input logic [12:0] onn,
                            input logic relu, input logic [15:0] bias,
                            input logic [31:0] ps, input int gap,
                            input logic [12:0] e_addr, input logic [15:0] e_data,
                            input logic e_ld);
    exp_t e;
    e.addr = e_addr;
    e.data = e_data;
    e.ld   = e_ld;
    oneuron_start_i = 1'b1;
    inn_i = inn; onn_i = onn; relu_en_i = relu; bias_i = bias;
    if (inn == 15'd0) begin
      e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    tick();
    oneuron_start_i = 1'b0;
    check_eq("busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < int'(inn); i++) begin
      psum_valid_i = 1'b1;
      psum_i = ps;
      if (i == int'(inn) - 1) begin
        e.cyc = cyc + 2;
        exp_q.push_back(e);
      end
      tick();
      psum_valid_i = 1'b0;
      if (i != int'(inn) - 1) repeat (gap) tick();
    end
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"},   32'(out_we_o),     32'd0);
    check_eq({tag, "_addr"}, 32'(out_addr_o),   32'd0);
    check_eq({tag, "_data"}, 32'(out_data_o),   32'd0);
    check_eq({tag, "_en"},   32'(output_en_o),  32'd0);
    check_eq({tag, "_ld"},   32'(layer_done_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_o),       32'd0);
    check_eq({tag, "_err"},  32'(err_o),        32'd0);
  endtask

  initial begin
    exp_t e;
    rst_i = 1'b1; oneuron_start_i = 1'b0; inn_i = 15'd0; onn_i = 13'd0;
    relu_en_i = 1'b0; bias_i = 16'd0; psum_valid_i = 1'b0; psum_i = 32'd0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();

    // Basic accumulate, onn=8 latched at idx 0.
    run_neuron(15'd4, 13'd8, 1'b0, 16'h0100, 32'h0001_0000, 0, 13'd0, 16'h0500, 1'b0);
    // ReLU on and off.
    run_neuron(15'd1, 13'd8, 1'b1, 16'hFF00, 32'h0, 0, 13'd1, 16'h0000, 1'b0);
    run_neuron(15'd1, 13'd8, 1'b0, 16'hFF00, 32'h0, 0, 13'd2, 16'hFF00, 1'b0);
    // Saturation and rounding; addr 7 is the last of an 8-neuron layer.
    run_neuron(15'd2, 13'd8, 1'b0, 16'h0000, 32'h7FFF_FFFF, 0, 13'd3, 16'h7FFF, 1'b0);
    run_neuron(15'd2, 13'd8, 1'b0, 16'h0000, 32'h8000_0000, 0, 13'd4, 16'h8000, 1'b0);
    run_neuron(15'd1, 13'd8, 1'b0, 16'h0000, 32'd384,       0, 13'd5, 16'h0002, 1'b0);
    run_neuron(15'd1, 13'd8, 1'b0, 16'h0000, -32'sd384,     0, 13'd6, 16'hFFFF, 1'b0);
    run_neuron(15'd1, 13'd8, 1'b0, 16'h0000, -32'sd128,     0, 13'd7, 16'h0000, 1'b1);
    check_eq("err_clean", 32'(err_o), 32'd0);

    // Layer end with onn=3 and 5-cycle gaps between psums.
    for (int k = 0; k < 3; k++) begin
      run_neuron(15'd2, 13'd3, 1'b0, 16'h0000, 32'((k + 1) * 256), 5,
                 13'(k), 16'(2 * (k + 1)), (k == 2));
    end
    // Bias-only neuron after the layer wrap goes to addr 0.
    run_neuron(15'd0, 13'd3, 1'b0, 16'h0123, 32'h0, 0, 13'd0, 16'h0123, 1'b0);

    // psum_valid in IDLE: flagged, dropped, following neuron unaffected.
    psum_valid_i = 1'b1; psum_i = 32'h1234_5678;
    tick();
    psum_valid_i = 1'b0;
    check_eq("err_idle_psum", 32'(err_o), 32'd1);
    run_neuron(15'd1, 13'd3, 1'b0, 16'h0100, 32'h0000_0100, 0, 13'd1, 16'h0101, 1'b0);
    check_eq("err_sticky", 32'(err_o), 32'd1);

    // Reset after 2 of 4 psums.
    oneuron_start_i = 1'b1; inn_i = 15'd4; bias_i = 16'h0300; onn_i = 13'd3;
    tick();
    oneuron_start_i = 1'b0;
    psum_valid_i = 1'b1; psum_i = 32'h100;
    repeat (2) tick();
    psum_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_all_zero("mid_rst");
    run_neuron(15'd1, 13'd4, 1'b0, 16'h0100, 32'h0, 0, 13'd0, 16'h0100, 1'b0);
    check_eq("err_after_rst", 32'(err_o), 32'd0);

    // Start while in ACC is ignored but flagged.
    oneuron_start_i = 1'b1; inn_i = 15'd2; bias_i = 16'h0200;
    tick();
    bias_i = 16'h7000; inn_i = 15'd0;
    tick();
    oneuron_start_i = 1'b0;
    check_eq("err_acc_start", 32'(err_o), 32'd1);
    psum_valid_i = 1'b1; psum_i = 32'h100;
    tick();
    e.addr = 13'd1; e.data = 16'h0202; e.ld = 1'b0; e.cyc = cyc + 2;
    exp_q.push_back(e);
    tick();
    psum_valid_i = 1'b0;
    wait_done();

    // Start and psum_valid together in IDLE: psum dropped.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("err_rst2", 32'(err_o), 32'd0);
    oneuron_start_i = 1'b1; inn_i = 15'd1; bias_i = 16'h0000; onn_i = 13'd4;
    psum_valid_i = 1'b1; psum_i = 32'h007F_FF00;
    tick();
    oneuron_start_i = 1'b0;
    psum_i = 32'h300;
    e.addr = 13'd0; e.data = 16'h0003; e.ld = 1'b0; e.cyc = cyc + 2;
    exp_q.push_back(e);
    tick();
    psum_valid_i = 1'b0;
    wait_done();
    check_eq("err_start_psum", 32'(err_o), 32'd1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
